// File: rtl/fxp_divider_pkg.sv
// Shared types and constants for the handshaked fixed-point divider.
// Holds the controller state encoding, the iteration count and the saturation limits.
package fxp_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // Number of CALC cycles needed to resolve the N+Q+1 quotient bits, K bits per cycle.
  function automatic int iter_count(input int n, input int q, input int k);
    return (n + q + 1 + k - 1) / k;
  endfunction

  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Magnitude of the most negative representable value.
  function automatic logic [63:0] sat_min_mag(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits and emit the resulting quotient bit.
module fxp_div_step #(
  parameter int N = 22
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] divisor_i,
  input  logic         bit_i,
  output logic [N:0]   rem_o,
  output logic         q_o
);

  logic [N:0] trial;

  always_comb begin
    trial = {rem_i[N-1:0], bit_i};
    // The remainder is always below the divisor, so rem_i[N] never sets; folding it
    // in keeps the compare exact for any input.
    q_o   = rem_i[N] | (trial >= {1'b0, divisor_i});
    rem_o = q_o ? (trial - {1'b0, divisor_i}) : trial;
  end

endmodule

// File: rtl/fxp_divider_hs.sv
// Iterative signed Q-format divider with valid/ready streams, K quotient bits per
// cycle, optional round-half-away-from-zero, saturation and a pass-through tag.
module fxp_divider_hs
  import fxp_divider_pkg::*;
#(
  parameter int N     = 22,
  parameter int Q     = 10,
  parameter int K     = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dividend,
  input  logic [N-1:0]     divisor,
  input  logic             round_en,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             dbz,
  output logic             overflow
);

  localparam int W    = N + Q + 1;
  localparam int ITER = iter_count(N, Q, K);
  localparam int PW   = ITER * K;
  localparam int SKIP = PW - W;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [N:0] SAT_MAX     = (N + 1)'(sat_max(N));
  localparam logic [N:0] SAT_MIN_MAG = (N + 1)'(sat_min_mag(N));

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N:0]       rem_q, rem_d;
  logic [PW-1:0]    num_q, num_d;
  logic [N-1:0]     div_q, div_d;
  logic             sign_q, sign_d;
  logic             rnd_q, rnd_d;
  logic             dbz_in_q, dbz_in_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     a_abs, b_abs;
  logic [N:0]       rem_chain [K+1];
  logic [K-1:0]     qbits;

  assign a_abs = dividend[N-1] ? (~dividend + 1'b1) : dividend;
  assign b_abs = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;

  // num_q holds the shifted dividend at the top and collects quotient bits at the
  // bottom; after ITER shifts it holds only the quotient.
  assign rem_chain[0] = rem_q;

  for (genvar j = 0; j < K; j++) begin : g_step
    localparam bit SURPLUS = (j < SKIP);
    logic [N:0] step_rem;
    logic       step_q;
    logic       bypass;

    fxp_div_step #(.N(N)) u_step (
      .rem_i     (rem_chain[j]),
      .divisor_i (div_q),
      .bit_i     (num_q[PW-1-j]),
      .rem_o     (step_rem),
      .q_o       (step_q)
    );

    // Surplus leading stages only exist in the first cycle when W is not a multiple of K.
    assign bypass            = SURPLUS && (cnt_q == '0);
    assign rem_chain[j+1]    = bypass ? rem_chain[j] : step_rem;
    assign qbits[K-1-j]      = bypass ? 1'b0 : step_q;
  end

  logic [W-1:0] mag;
  logic [W-1:0] r_full;
  logic [N:0]   r_low;
  logic         r_hi;
  logic         pos_ovf, neg_ovf;

  always_comb begin
    mag     = num_q[W-1:0];
    r_full  = {1'b0, mag[W-1:1]} + W'(rnd_q & mag[0]);
    r_hi    = |r_full[W-1:N+1];
    r_low   = r_full[N:0];
    pos_ovf = r_hi || (r_low > SAT_MAX);
    neg_ovf = r_hi || (r_low > SAT_MIN_MAG);
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    num_d      = num_q;
    div_d      = div_q;
    sign_d     = sign_q;
    rnd_d      = rnd_q;
    dbz_in_d   = dbz_in_q;
    tag_d      = tag_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d          = '0;
          num_d[W-1:0]   = {a_abs, {(Q + 1){1'b0}}};
          rem_d          = '0;
          cnt_d          = '0;
          div_d          = b_abs;
          sign_d         = dividend[N-1] ^ divisor[N-1];
          rnd_d          = round_en;
          dbz_in_d       = (divisor == '0);
          tag_d          = in_tag;
          state_d        = CALC;
        end
      end
      CALC: begin
        // A zero divisor still spends ITER cycles here, counting only, so latency is fixed.
        cnt_d = cnt_q + 1'b1;
        if (!dbz_in_q) begin
          rem_d = rem_chain[K];
          num_d = {num_q[PW-K-1:0], qbits};
        end
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        out_tag_d = tag_q;
        dbz_d     = dbz_in_q;
        if (dbz_in_q) begin
          ovf_d      = 1'b0;
          out_data_d = sign_q ? SAT_MIN_MAG[N-1:0] : SAT_MAX[N-1:0];
        end else if (!sign_q) begin
          ovf_d      = pos_ovf;
          out_data_d = pos_ovf ? SAT_MAX[N-1:0] : r_low[N-1:0];
        end else begin
          ovf_d      = neg_ovf;
          out_data_d = neg_ovf ? SAT_MIN_MAG[N-1:0] : (~r_low[N-1:0] + 1'b1);
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      div_q      <= '0;
      sign_q     <= 1'b0;
      rnd_q      <= 1'b0;
      dbz_in_q   <= 1'b0;
      tag_q      <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      num_q      <= num_d;
      div_q      <= div_d;
      sign_q     <= sign_d;
      rnd_q      <= rnd_d;
      dbz_in_q   <= dbz_in_d;
      tag_q      <= tag_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign dbz       = dbz_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fxp_divider_hs.sv
// Directed bench for fxp_divider_hs: three instances (K=1,2,3) share operand inputs
// and each has its own handshake; expected results are hand-computed Q10 values.
module tb_fxp_divider_hs;

  localparam int N     = 22;
  localparam int Q     = 10;
  localparam int TAG_W = 4;
  localparam int NU    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     dividend;
  logic [N-1:0]     divisor;
  logic             round_en;
  logic [TAG_W-1:0] in_tag;

  logic             in_valid_v  [NU];
  logic             out_ready_v [NU];
  logic             in_ready_v  [NU];
  logic             out_valid_v [NU];
  logic [N-1:0]     out_data_v  [NU];
  logic [TAG_W-1:0] out_tag_v   [NU];
  logic             dbz_v       [NU];
  logic             ovf_v       [NU];

  int checks = 0;
  int errors = 0;

  // Cycles from the offer/accept cycle to the first cycle with out_valid: ITER+2.
  int lat_exp [NU] = '{35, 19, 13};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    fxp_divider_hs #(.N(N), .Q(Q), .K(g + 1), .TAG_W(TAG_W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .dividend  (dividend),
      .divisor   (divisor),
      .round_en  (round_en),
      .in_tag    (in_tag),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_data  (out_data_v[g]),
      .out_tag   (out_tag_v[g]),
      .dbz       (dbz_v[g]),
      .overflow  (ovf_v[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with unit u idle; returns at a negedge with the unit idle again
  // when out_ready is high, or still presenting its result when out_ready is low.
  task automatic run_op(input int u, input string name,
                        input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                        input logic rnd, input logic [TAG_W-1:0] tag,
                        input logic [N-1:0] exp_data, input logic exp_dbz,
                        input logic exp_ovf);
    int lat;
    check({name, ".in_ready_before"}, 64'(in_ready_v[u]), 64'd1);
    dividend       = dvd;
    divisor        = dvs;
    round_en       = rnd;
    in_tag         = tag;
    in_valid_v[u]  = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid_v[u] = 1'b0;
    dividend      = '1;
    divisor       = 22'h155555;
    round_en      = ~rnd;
    in_tag        = ~tag;
    check({name, ".in_ready_busy"}, 64'(in_ready_v[u]), 64'd0);
    while (!out_valid_v[u] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, ".latency"}, 64'(lat), 64'(lat_exp[u]));
    check({name, ".data"}, 64'(out_data_v[u]), 64'(exp_data));
    check({name, ".tag"}, 64'(out_tag_v[u]), 64'(tag));
    check({name, ".dbz"}, 64'(dbz_v[u]), 64'(exp_dbz));
    check({name, ".ovf"}, 64'(ovf_v[u]), 64'(exp_ovf));
    if (out_ready_v[u]) begin
      @(posedge clk);
      @(negedge clk);
      check({name, ".valid_dropped"}, 64'(out_valid_v[u]), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < NU; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b1;
    end
    dividend = '0;
    divisor  = '0;
    round_en = 1'b0;
    in_tag   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.in_ready", 64'(in_ready_v[0]), 64'd1);
    check("rst.out_valid", 64'(out_valid_v[0]), 64'd0);
    check("rst.out_data", 64'(out_data_v[0]), 64'd0);
    check("rst.out_tag", 64'(out_tag_v[0]), 64'd0);
    check("rst.dbz", 64'(dbz_v[0]), 64'd0);
    check("rst.ovf", 64'(ovf_v[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // K=1 directed vectors
    run_op(0, "k1.3_div_2",     N'(3072),     N'(2048),   1'b0, 4'h5, N'(1536),     1'b0, 1'b0);
    run_op(0, "k1.2_div_3_trn", N'(2048),     N'(3072),   1'b0, 4'h1, N'(682),      1'b0, 1'b0);
    run_op(0, "k1.2_div_3_rnd", N'(2048),     N'(3072),   1'b1, 4'h2, N'(683),      1'b0, 1'b0);
    run_op(0, "k1.m2_div_3_trn",N'(-2048),    N'(3072),   1'b0, 4'h3, N'(-682),     1'b0, 1'b0);
    run_op(0, "k1.m2_div_3_rnd",N'(-2048),    N'(3072),   1'b1, 4'h4, N'(-683),     1'b0, 1'b0);
    run_op(0, "k1.7p5_div_m2p5",N'(7680),     N'(-2560),  1'b0, 4'h6, N'(-3072),    1'b0, 1'b0);
    run_op(0, "k1.ovf_pos",     N'(2097151),  N'(1),      1'b0, 4'h7, N'(2097151),  1'b0, 1'b1);
    run_op(0, "k1.ovf_negneg",  N'(-2097152), N'(-1024),  1'b0, 4'h8, N'(2097151),  1'b0, 1'b1);
    run_op(0, "k1.min_exact",   N'(-2097152), N'(1024),   1'b0, 4'h9, N'(-2097152), 1'b0, 1'b0);
    run_op(0, "k1.dbz_pos",     N'(5120),     N'(0),      1'b0, 4'hA, N'(2097151),  1'b1, 1'b0);
    run_op(0, "k1.dbz_neg",     N'(-5120),    N'(0),      1'b1, 4'hB, N'(-2097152), 1'b1, 1'b0);
    run_op(0, "k1.zero_negdiv", N'(0),        N'(-3072),  1'b1, 4'hC, N'(0),        1'b0, 1'b0);
    run_op(0, "k1.tiny_neg_trn",N'(-1),       N'(2048),   1'b0, 4'hD, N'(0),        1'b0, 1'b0);
    run_op(0, "k1.tiny_neg_rnd",N'(-1),       N'(2048),   1'b1, 4'hE, N'(-1),       1'b0, 1'b0);

    // Backpressure: result held for 10 cycles with out_ready low
    out_ready_v[0] = 1'b0;
    run_op(0, "bp.10_div_4", N'(10240), N'(4096), 1'b0, 4'h9, N'(2560), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp.valid_held", 64'(out_valid_v[0]), 64'd1);
      check("bp.in_ready_low", 64'(in_ready_v[0]), 64'd0);
      check("bp.data_held", 64'(out_data_v[0]), 64'(N'(2560)));
      check("bp.tag_held", 64'(out_tag_v[0]), 64'h9);
      check("bp.flags_held", 64'({dbz_v[0], ovf_v[0]}), 64'd0);
    end
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.in_ready_after", 64'(in_ready_v[0]), 64'd1);
    check("bp.valid_after", 64'(out_valid_v[0]), 64'd0);
    run_op(0, "bp.back_to_back", N'(2097151), N'(1), 1'b0, 4'hA, N'(2097151), 1'b0, 1'b1);

    // Reset 10 cycles into CALC aborts the operation and clears the outputs
    dividend      = N'(3072);
    divisor       = N'(2048);
    round_en      = 1'b0;
    in_tag        = 4'h3;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.out_data", 64'(out_data_v[0]), 64'd0);
    check("abort.out_tag", 64'(out_tag_v[0]), 64'd0);
    check("abort.flags", 64'({dbz_v[0], ovf_v[0]}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort.in_ready", 64'(in_ready_v[0]), 64'd1);
    check("abort.out_valid", 64'(out_valid_v[0]), 64'd0);
    @(negedge clk);
    run_op(0, "abort.next_op", N'(-2048), N'(3072), 1'b1, 4'h6, N'(-683), 1'b0, 1'b0);

    // K=2 and K=3: same arithmetic, shorter latency
    for (int u = 1; u < NU; u++) begin
      run_op(u, "kx.3_div_2",      N'(3072),     N'(2048),  1'b0, 4'h1, N'(1536),     1'b0, 1'b0);
      run_op(u, "kx.2_div_3_rnd",  N'(2048),     N'(3072),  1'b1, 4'h2, N'(683),      1'b0, 1'b0);
      run_op(u, "kx.m2_div_3_trn", N'(-2048),    N'(3072),  1'b0, 4'h3, N'(-682),     1'b0, 1'b0);
      run_op(u, "kx.7p5_div_m2p5", N'(7680),     N'(-2560), 1'b0, 4'h4, N'(-3072),    1'b0, 1'b0);
      run_op(u, "kx.ovf_negneg",   N'(-2097152), N'(-1024), 1'b0, 4'h5, N'(2097151),  1'b0, 1'b1);
      run_op(u, "kx.min_exact",    N'(-2097152), N'(1024),  1'b0, 4'h6, N'(-2097152), 1'b0, 1'b0);
      run_op(u, "kx.dbz_neg",      N'(-5120),    N'(0),     1'b0, 4'h7, N'(-2097152), 1'b1, 1'b0);
      run_op(u, "kx.tiny_neg_rnd", N'(-1),       N'(2048),  1'b1, 4'h8, N'(-1),       1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
